// File: rtl/laundry_scheduler.sv
// Job front-end for a bank of wash machines: queues paid jobs and dispatches
// them round-robin to idle machines, refunding coins that cannot be accepted.
module laundry_scheduler #(
   parameter int unsigned NUM_MACH = 4,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_coin,
   input  logic                          i_DoubleWash,
   input  logic [NUM_MACH-1:0]           i_Done,
   output logic [NUM_MACH-1:0]           o_Start,
   output logic [NUM_MACH-1:0]           o_DoubleWash,
   output logic [NUM_MACH-1:0]           o_Busy,
   output logic [$clog2(QDEPTH+1)-1:0]   o_QCount,
   output logic                          o_Full,
   output logic                          o_Refund,
   output logic                          o_Err
);

   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned MW    = $clog2(NUM_MACH);
   localparam int unsigned IDX_W = MW + 1;

   logic [QDEPTH-1:0]   fifoMem;
   logic [PTR_W-1:0]    rdPtr;
   logic [PTR_W-1:0]    wrPtr;
   logic [MW-1:0]       rrPtr;

   logic                found;
   logic [MW-1:0]       tgt;
   logic [IDX_W-1:0]    idx;
   logic                pop;
   logic                push;
   logic [NUM_MACH-1:0] tgtOneHot;
   logic [NUM_MACH-1:0] doneHit;
   logic [MW-1:0]       rrNext;
   logic [CNT_W-1:0]    cntNext;
   logic                headFlag;

   // Pick the first idle machine at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      tgt   = '0;
      idx   = '0;
      for (int i = 0; i < int'(NUM_MACH); i++) begin
         idx = IDX_W'(rrPtr) + IDX_W'(i);
         if (idx >= IDX_W'(NUM_MACH)) begin
            idx = idx - IDX_W'(NUM_MACH);
         end
         if (!found && !o_Busy[idx[MW-1:0]]) begin
            found = 1'b1;
            tgt   = idx[MW-1:0];
         end
      end
   end

   // Push/pop decisions use the pre-edge queue count and busy state.
   always_comb begin
      pop       = (o_QCount != '0) && found;
      push      = i_coin && ((o_QCount != CNT_W'(QDEPTH)) || pop);
      tgtOneHot = pop ? (NUM_MACH'(1) << tgt) : '0;
      doneHit   = i_Done & o_Busy;
      headFlag  = fifoMem[rdPtr];
      rrNext    = (tgt == MW'(NUM_MACH - 1)) ? '0 : tgt + MW'(1);
      cntNext   = o_QCount;
      if (push && !pop) begin
         cntNext = o_QCount + CNT_W'(1);
      end else if (pop && !push) begin
         cntNext = o_QCount - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifoMem      <= '0;
         rdPtr        <= '0;
         wrPtr        <= '0;
         rrPtr        <= '0;
         o_Start      <= '0;
         o_DoubleWash <= '0;
         o_Busy       <= '0;
         o_QCount     <= '0;
         o_Full       <= 1'b0;
         o_Refund     <= 1'b0;
         o_Err        <= 1'b0;
      end else begin
         o_Start      <= tgtOneHot;
         o_Busy       <= (o_Busy & ~doneHit) | tgtOneHot;
         o_DoubleWash <= (o_DoubleWash & ~doneHit) | (tgtOneHot & {NUM_MACH{headFlag}});
         o_QCount     <= cntNext;
         o_Full       <= (cntNext == CNT_W'(QDEPTH));
         o_Refund     <= i_coin && !push;
         o_Err        <= o_Err || ((i_Done & ~o_Busy) != '0);
         if (push) begin
            fifoMem[wrPtr] <= i_DoubleWash;
            wrPtr          <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
            rrPtr <= rrNext;
         end
      end
   end

endmodule

// File: tb/tb_laundry_scheduler.sv
// Randomized bench for laundry_scheduler against a queue-based job model.
module tb_laundry_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned QD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         coin = 1'b0;
   logic         dwIn = 1'b0;
   logic [N-1:0] done = '0;
   logic [N-1:0] oStart, oDw, oBusy;
   logic [2:0]   oQCount;
   logic         oFull, oRefund, oErr;

   int nTests = 0;
   int nFail  = 0;

   // reference model state
   bit mBusy[N];
   bit mDw[N];
   bit mStart[N];
   bit fifo[$];
   int rr;
   bit mRefund;
   bit mErr;

   laundry_scheduler #(.NUM_MACH(N), .QDEPTH(QD)) dut (
      .clk(clk), .rst(rst), .i_coin(coin), .i_DoubleWash(dwIn), .i_Done(done),
      .o_Start(oStart), .o_DoubleWash(oDw), .o_Busy(oBusy), .o_QCount(oQCount),
      .o_Full(oFull), .o_Refund(oRefund), .o_Err(oErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int m = 0; m < N; m++) begin
         mBusy[m] = 0; mDw[m] = 0; mStart[m] = 0;
      end
      fifo.delete();
      rr = 0; mRefund = 0; mErr = 0;
   endtask

   // One clock edge of the scheduler's rules applied to the model.
   task automatic modelEdge(input bit c, input bit d, input logic [N-1:0] dn);
      int  tgt;
      bit  pop, push, f;
      tgt = -1;
      for (int k = 0; k < N; k++) begin
         if (tgt < 0 && !mBusy[(rr + k) % N]) tgt = (rr + k) % N;
      end
      pop  = (fifo.size() > 0) && (tgt >= 0);
      push = c && ((fifo.size() < QD) || pop);
      for (int m = 0; m < N; m++) begin
         mStart[m] = 0;
         if (dn[m] && !mBusy[m]) mErr = 1;
      end
      for (int m = 0; m < N; m++) begin
         if (dn[m] && mBusy[m]) begin
            mBusy[m] = 0; mDw[m] = 0;
         end
      end
      if (pop) begin
         f = fifo.pop_front();
         mBusy[tgt] = 1; mDw[tgt] = f; mStart[tgt] = 1;
         rr = (tgt + 1) % N;
      end
      if (push) fifo.push_back(d);
      mRefund = c && !push;
   endtask

   function automatic logic [N-1:0] pack(input bit a[N]);
      logic [N-1:0] v;
      for (int m = 0; m < N; m++) v[m] = a[m];
      return v;
   endfunction

   task automatic compareAll();
      check("start",  32'(oStart),  32'(pack(mStart)));
      check("busy",   32'(oBusy),   32'(pack(mBusy)));
      check("dwash",  32'(oDw),     32'(pack(mDw)));
      check("qcount", 32'(oQCount), 32'(fifo.size()));
      check("full",   32'(oFull),   32'(fifo.size() == QD));
      check("refund", 32'(oRefund), 32'(mRefund));
      check("err",    32'(oErr),    32'(mErr));
   endtask

   task automatic checkZero(input string tag);
      check(tag, {oStart, oDw, oBusy, oQCount, oFull, oRefund, oErr}, 32'd0);
   endtask

   // Drive inputs for one edge, advance the model, compare after the edge.
   task automatic step(input bit c, input bit d, input logic [N-1:0] dn);
      coin = c; dwIn = d; done = dn;
      @(posedge clk);
      modelEdge(c, d, dn);
      #1;
      coin = 0; dwIn = 0; done = '0;
      compareAll();
   endtask

   task automatic randPhase(input int cycles, input int coinPct, input int doneDiv, input bit spurious);
      logic [N-1:0] dn;
      for (int t = 0; t < cycles; t++) begin
         for (int m = 0; m < N; m++) begin
            if (spurious) dn[m] = ($urandom % 8) == 0;
            else          dn[m] = mBusy[m] && (($urandom % doneDiv) == 0);
         end
         step(($urandom % 100) < coinPct, 1'($urandom), dn);
      end
   endtask

   task automatic asyncReset();
      @(posedge clk);
      #3 rst = 1;
      #1 checkZero("async_rst_zero");
      modelReset();
      @(posedge clk);
      #1 checkZero("rst_hold_zero");
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      modelReset();
      coin = 0; dwIn = 0; done = '0;
      #12 checkZero("reset_zero");
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;

      // single job latency: coin at edge 0, start visible after edge 1 only
      step(1, 1, '0);
      check("lat_no_start_yet", 32'(oStart), 32'd0);
      check("lat_queued", 32'(oQCount), 32'd1);
      step(0, 0, '0);
      check("lat_start0", 32'(oStart), 32'b0001);
      check("lat_dw0", 32'(oDw), 32'b0001);
      step(0, 0, '0);
      check("start_one_cycle", 32'(oStart), 32'd0);
      step(0, 0, 4'b0001);
      check("done_clears", 32'({oBusy, oDw}), 32'd0);

      // round robin and overflow; full plus simultaneous dispatch
      for (int i = 0; i < 5; i++) step(1, 1'(i), '0);
      step(0, 0, '0);
      check("rr_all_busy", 32'(oBusy), 32'hF);
      check("rr_one_waits", 32'(oQCount), 32'd1);
      for (int i = 0; i < 4; i++) step(1, 0, '0);
      check("overflow_refund", 32'(oRefund), 32'd1);
      check("overflow_full", 32'(oFull), 32'd1);
      step(0, 0, 4'b0100);
      step(1, 1, '0);
      check("full_pop_start2", 32'(oStart), 32'b0100);
      check("full_pop_norefund", 32'(oRefund), 32'd0);
      check("full_pop_qcount", 32'(oQCount), 32'd4);

      randPhase(1500, 50, 6, 0);
      randPhase(800, 90, 20, 0);
      asyncReset();
      for (int i = 0; i < 5; i++) step(0, 0, '0);
      check("post_rst_no_start", 32'(oStart), 32'd0);
      randPhase(600, 60, 5, 0);
      randPhase(300, 40, 5, 1);
      check("err_sticky", 32'(oErr), 32'd1);
      asyncReset();
      randPhase(1500, 70, 8, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/laundry_scheduler.md
Name: laundry_scheduler

Overview:
- Front-end job scheduler for a bank of NUM_MACH wash-machine FSMs sharing one coin slot.
- Paid jobs (coin + double-wash option) are queued in a small FIFO and dispatched round-robin to idle machines.
- Each dispatch drives that machine's coin input with a one-cycle start pulse and holds its double-wash select until the machine reports done.
- Coins that arrive when no job can be accepted are refunded.

Parameters:
- NUM_MACH, 4, number of wash machines served (2..8).
- QDEPTH, 4, job FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_coin  in  1  one-cycle pulse: customer paid for one job.
- i_DoubleWash  in  1  double-wash option, sampled with i_coin.
- i_Done  in  NUM_MACH  per-machine done pulse (machine Dn), one cycle.
- o_Start  out  NUM_MACH  per-machine one-cycle start pulse (drives machine i_coin).
- o_DoubleWash  out  NUM_MACH  per-machine double-wash select, held for the whole job.
- o_Busy  out  NUM_MACH  machine has a job in progress.
- o_QCount  out  clog2(QDEPTH+1)  jobs waiting in the FIFO.
- o_Full  out  1  o_QCount == QDEPTH.
- o_Refund  out  1  one-cycle pulse: last coin rejected.
- o_Err  out  1  sticky: i_Done seen on a non-busy machine.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; FIFO emptied; round-robin pointer = 0.
  - Applies at any time, including mid-job: all in-flight jobs are forgotten and no start pulse is emitted after reset.
  - Outputs are forced 0 while rst is high.
- Registers: all outputs are registered; no combinational path from input to output.
- FIFO entry: 1 bit (the double-wash flag).
- Push:
  - On an edge with i_coin=1, the job is pushed if o_QCount < QDEPTH, or if a pop occurs on the same edge.
  - Otherwise the job is dropped and o_Refund=1 for the following cycle.
- Pop/dispatch on an edge requires both:
  - FIFO non-empty, using the value before this edge's push; a coin is never dispatched on the same edge it is pushed.
  - At least one machine with o_Busy=0.
- Dispatch target: the first idle machine scanning from the RR pointer upward, wrapping modulo NUM_MACH.
  - After dispatch to machine m: pointer = (m+1) mod NUM_MACH.
  - At most one dispatch per edge.
- Dispatch effects, all visible in the cycle after the edge:
  - o_Start[m]=1 for exactly one cycle.
  - o_Busy[m]=1.
  - o_DoubleWash[m] = entry flag, stable from o_Start[m] rising until o_Busy[m] falls.
- Latency: coin sampled at edge N with a machine idle and the FIFO empty gives o_Start high between edges N+1 and N+2.
- Completion:
  - i_Done[m]=1 while o_Busy[m]=1 clears o_Busy[m] and o_DoubleWash[m] at that edge.
  - Machine m becomes eligible for dispatch from the next edge; there is no same-edge reuse.
- Error: i_Done[m]=1 while o_Busy[m]=0 sets o_Err, which holds until reset. Busy state is unchanged.
- Multiple i_Done bits may be high on the same edge; each is handled independently.
- o_QCount:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - Never exceeds QDEPTH and never underflows.
- Full and simultaneous coin: with the FIFO full and a dispatch on the same edge, the coin is accepted, o_QCount stays at QDEPTH, and there is no refund.

Test Plan:
1. Single job, NUM_MACH=4 all idle: i_coin=1, i_DoubleWash=1 at edge 0 -> o_Start=4'b0001 in cycle after edge 1 only; o_Busy[0]=1 and o_DoubleWash[0]=1 held; i_Done[0] pulse -> both clear next cycle; o_QCount returns to 0.
2. Round-robin: 5 coins on consecutive edges, no dones -> starts go to machines 0,1,2,3 in order; 5th job waits with o_QCount=1; i_Done[2] pulse -> job dispatched to machine 2 one edge later.
3. Overflow: all 4 machines busy, 5 coins -> first 4 queued (o_Full=1), 5th gives o_Refund one-cycle pulse, o_QCount=4.
4. Full plus simultaneous pop: FIFO full, i_Done[1] at edge k, coin at edge k+1 (same edge as the dispatch) -> coin accepted, o_QCount stays 4, no refund, o_Start[1] pulse.
5. Spurious done: i_Done[3]=1 while idle -> o_Err=1 sticky; other machines unaffected.
6. Reset mid-operation: 2 machines busy and 2 jobs queued, assert rst asynchronously between edges -> all outputs 0 immediately; after release, no o_Start until a new coin arrives.
